// File: rtl/bus_arbiter_lv1_lv2.sv
// ----------------------------------------------------------------------------
// bus_arbiter_lv1_lv2
//
// Arbiter for the shared lv1<->lv2 bus. It grants one processor-side
// transaction at a time and rotates that grant round-robin across the cores.
// While a core owns the bus, the arbiter serialises the snoop responders and
// the lv2 responder. A watchdog raises a sticky flag when a proc transaction
// holds the bus for too long.
//
// Parameters
//   NUM_CORES    number of lv1 cores (2 or 4); request bits above NUM_CORES are ignored
//   ID_WID       width of the owner index
//   BUS_TIMEOUT  cycles of continuous proc grant before timeout_err sets (0 = off)
//
// Ports
//   clk                    in   system clock, all logic on posedge
//   rst                    in   synchronous active-high reset
//   bus_lv1_lv2_req_proc   in   per-core proc request, held until the transaction is done
//   bus_lv1_lv2_gnt_proc   out  one-hot proc grant
//   bus_lv1_lv2_req_snoop  in   per-core snoop request
//   bus_lv1_lv2_gnt_snoop  out  one-hot snoop grant
//   bus_lv1_lv2_req_lv2    in   lv2 request to drive the bus
//   bus_lv1_lv2_gnt_lv2    out  lv2 grant
//   bus_busy               out  any grant asserted
//   bus_owner_id           out  index of the current or last proc owner
//   timeout_err            out  sticky watchdog flag, cleared only by rst
// ----------------------------------------------------------------------------
module bus_arbiter_lv1_lv2 #(
    parameter int NUM_CORES   = 4,
    parameter int ID_WID      = 2,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        bus_lv1_lv2_req_proc,
    output logic [3:0]        bus_lv1_lv2_gnt_proc,
    input  logic [3:0]        bus_lv1_lv2_req_snoop,
    output logic [3:0]        bus_lv1_lv2_gnt_snoop,
    input  logic              bus_lv1_lv2_req_lv2,
    output logic              bus_lv1_lv2_gnt_lv2,
    output logic              bus_busy,
    output logic [ID_WID-1:0] bus_owner_id,
    output logic              timeout_err
);

    // REL_SNP / REL_LV2: the owner has already dropped its proc request, but
    // the sub-grant it started must run to completion before the bus is free.
    typedef enum logic [2:0] {
        IDLE,
        OWN,
        OWN_SNP,
        OWN_LV2,
        REL_SNP,
        REL_LV2
    } state_t;

    localparam logic [3:0] CORE_MASK = (NUM_CORES == 2) ? 4'b0011 : 4'b1111;
    localparam int WD_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(BUS_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [ID_WID-1:0] proc_ptr_q, proc_ptr_d;
    logic [ID_WID-1:0] snoop_ptr_q, snoop_ptr_d;
    logic [ID_WID-1:0] owner_d;
    logic [ID_WID-1:0] proc_win, snoop_win;
    logic [WD_W-1:0]   wd_cnt_q;
    logic [3:0]        req_proc_m, req_snoop_m, owner_mask;
    logic [3:0]        gnt_proc_d, gnt_snoop_d;
    logic              gnt_lv2_d, busy_d;
    logic              owner_req, snoop_req;

    // First requester found walking upward from ptr+1, wrapping at NUM_CORES.
    // The loop runs backwards so the nearest candidate is the last to assign.
    function automatic logic [ID_WID-1:0] rr_pick(input logic [3:0]        req,
                                                  input logic [ID_WID-1:0] ptr);
        logic [ID_WID-1:0] pick;
        int                idx;
        pick = ptr;
        for (int i = NUM_CORES; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_CORES;
            if (req[idx[1:0]]) pick = ID_WID'(idx);
        end
        return pick;
    endfunction

    // The owner never snoops its own transaction, so its snoop bit is masked.
    // The snoop pointer doubles as the index of the active snoop grant.
    assign req_proc_m  = bus_lv1_lv2_req_proc & CORE_MASK;
    assign owner_mask  = 4'b0001 << bus_owner_id;
    assign req_snoop_m = bus_lv1_lv2_req_snoop & CORE_MASK & ~owner_mask;
    assign owner_req   = |(req_proc_m & owner_mask);
    assign snoop_req   = |(bus_lv1_lv2_req_snoop & (4'b0001 << snoop_ptr_q));

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= IDLE;
            proc_ptr_q            <= ID_WID'(NUM_CORES - 1);
            snoop_ptr_q           <= ID_WID'(NUM_CORES - 1);
            bus_owner_id          <= '0;
            bus_lv1_lv2_gnt_proc  <= '0;
            bus_lv1_lv2_gnt_snoop <= '0;
            bus_lv1_lv2_gnt_lv2   <= 1'b0;
            bus_busy              <= 1'b0;
        end else begin
            state_q               <= state_d;
            proc_ptr_q            <= proc_ptr_d;
            snoop_ptr_q           <= snoop_ptr_d;
            bus_owner_id          <= owner_d;
            bus_lv1_lv2_gnt_proc  <= gnt_proc_d;
            bus_lv1_lv2_gnt_snoop <= gnt_snoop_d;
            bus_lv1_lv2_gnt_lv2   <= gnt_lv2_d;
            bus_busy              <= busy_d;
        end
    end

    // Next-state logic. Sub-arbitration only starts from OWN, so a released
    // sub-grant always leaves one bubble cycle before the next one.
    always_comb begin
        state_d   = state_q;
        proc_win  = rr_pick(req_proc_m, proc_ptr_q);
        snoop_win = rr_pick(req_snoop_m, snoop_ptr_q);
        case (state_q)
            IDLE: begin
                if (|req_proc_m) state_d = OWN;
            end
            OWN: begin
                if (!owner_req)               state_d = IDLE;
                else if (|req_snoop_m)        state_d = OWN_SNP;
                else if (bus_lv1_lv2_req_lv2) state_d = OWN_LV2;
            end
            OWN_SNP: begin
                if (!snoop_req)     state_d = owner_req ? OWN : IDLE;
                else if (!owner_req) state_d = REL_SNP;
            end
            OWN_LV2: begin
                if (!bus_lv1_lv2_req_lv2) state_d = owner_req ? OWN : IDLE;
                else if (!owner_req)      state_d = REL_LV2;
            end
            REL_SNP: begin
                if (!snoop_req) state_d = IDLE;
            end
            REL_LV2: begin
                if (!bus_lv1_lv2_req_lv2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state so
    // every grant appears on the edge that moves the FSM.
    always_comb begin
        proc_ptr_d  = proc_ptr_q;
        snoop_ptr_d = snoop_ptr_q;
        owner_d     = bus_owner_id;
        if (state_q == IDLE && state_d == OWN) begin
            proc_ptr_d = proc_win;
            owner_d    = proc_win;
        end
        if (state_q == OWN && state_d == OWN_SNP) snoop_ptr_d = snoop_win;

        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        gnt_lv2_d   = 1'b0;
        case (state_d)
            OWN: begin
                gnt_proc_d = 4'b0001 << owner_d;
            end
            OWN_SNP: begin
                gnt_proc_d  = 4'b0001 << owner_d;
                gnt_snoop_d = 4'b0001 << snoop_ptr_d;
            end
            OWN_LV2: begin
                gnt_proc_d = 4'b0001 << owner_d;
                gnt_lv2_d  = 1'b1;
            end
            REL_SNP: begin
                gnt_snoop_d = 4'b0001 << snoop_ptr_d;
            end
            REL_LV2: begin
                gnt_lv2_d = 1'b1;
            end
            default: ;
        endcase
        busy_d = (|gnt_proc_d) | (|gnt_snoop_d) | gnt_lv2_d;
    end

    // Watchdog: counts cycles with a proc grant visible, saturating, and is
    // cleared once the bus is back in IDLE. It only flags; grants stay up.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else if (|bus_lv1_lv2_gnt_proc) begin
            if (wd_cnt_q < WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (BUS_TIMEOUT > 0 && wd_cnt_q >= WD_LAST) timeout_err <= 1'b1;
        end else if (state_q == IDLE) begin
            wd_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_lv1_lv2.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_lv1_lv2
//
// Directed scenarios for fairness, snoop rotation, snoop-over-lv2 priority,
// owner release during a sub-grant, watchdog and mid-transaction reset,
// followed by randomized traffic compared against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_lv1_lv2;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_proc, gnt_proc, req_snoop, gnt_snoop;
    logic       req_lv2, gnt_lv2, bus_busy, timeout_err;
    logic [1:0] bus_owner_id;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_arbiter_lv1_lv2 #(
        .NUM_CORES  (4),
        .ID_WID     (2),
        .BUS_TIMEOUT(TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus_lv1_lv2_req_proc (req_proc),
        .bus_lv1_lv2_gnt_proc (gnt_proc),
        .bus_lv1_lv2_req_snoop(req_snoop),
        .bus_lv1_lv2_gnt_snoop(gnt_snoop),
        .bus_lv1_lv2_req_lv2  (req_lv2),
        .bus_lv1_lv2_gnt_lv2  (gnt_lv2),
        .bus_busy             (bus_busy),
        .bus_owner_id         (bus_owner_id),
        .timeout_err          (timeout_err)
    );

    // Reference model: who holds the bus, described as transactions.
    bit         m_proc;   // a core holds the proc grant
    int         m_sub;    // 0 none, 1 snoop responder, 2 lv2 responder
    logic [1:0] m_owner, m_ptr, m_sptr, m_sidx;
    int         m_wd;
    bit         m_terr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_proc  = '0;
        req_snoop = '0;
        req_lv2   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] rr_next(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (req[idx]) return idx;
        end
        return ptr;
    endfunction

    task automatic model_reset;
        m_proc  = 0;
        m_sub   = 0;
        m_owner = 2'd0;
        m_ptr   = 2'd3;
        m_sptr  = 2'd3;
        m_sidx  = 2'd0;
        m_wd    = 0;
        m_terr  = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step;
        logic [3:0] others;
        bit         sub_req;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_proc) begin
            if (m_wd < TMO) m_wd++;
            if (m_wd >= TMO) m_terr = 1;
        end else if (m_sub == 0) begin
            m_wd = 0;
        end

        if (!m_proc && m_sub == 0) begin
            if (req_proc != 0) begin
                m_owner = rr_next(req_proc, m_ptr);
                m_ptr   = m_owner;
                m_proc  = 1;
            end
        end else if (m_proc && m_sub == 0) begin
            others = req_snoop;
            others[m_owner] = 1'b0;
            if (!req_proc[m_owner]) begin
                m_proc = 0;
            end else if (others != 0) begin
                m_sptr = rr_next(others, m_sptr);
                m_sidx = m_sptr;
                m_sub  = 1;
            end else if (req_lv2) begin
                m_sub = 2;
            end
        end else begin
            sub_req = (m_sub == 1) ? req_snoop[m_sidx] : req_lv2;
            if (m_proc && !req_proc[m_owner]) m_proc = 0;
            if (!sub_req) m_sub = 0;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_proc  = 4'b1111;
        req_snoop = 4'b1111;
        req_lv2   = 1'b1;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop, gnt_lv2, bus_busy, bus_owner_id, timeout_err} !== 13'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b, expected %b",
                     {gnt_proc, gnt_snoop, gnt_lv2, bus_busy, bus_owner_id, timeout_err}, 13'b0);
        end
        rst       = 1'b0;
        req_snoop = '0;
        req_lv2   = 1'b0;
        tick();
        tests_run++;
        if ({gnt_proc, bus_owner_id, bus_busy} !== {4'b0001, 2'd0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL first_grant: got %b, expected %b",
                     {gnt_proc, bus_owner_id, bus_busy}, {4'b0001, 2'd0, 1'b1});
        end
    endtask

    task automatic test_proc_fairness;
        int         seq[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp;
        do_reset();
        req_proc = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << seq[k];
            tests_run++;
            if ({gnt_proc, bus_owner_id} !== {exp, 2'(seq[k])}) begin
                tests_failed++;
                $display("[TB] FAIL fairness_grant %0d: got %b, expected %b",
                         k, {gnt_proc, bus_owner_id}, {exp, 2'(seq[k])});
            end
            if (k < 4) begin
                req_proc = 4'b1111 & ~exp;
                tick();
                tests_run++;
                if ({gnt_proc, bus_busy} !== 5'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL fairness_idle_gap %0d: got %b, expected %b",
                             k, {gnt_proc, bus_busy}, 5'b0);
                end
                req_proc = 4'b1111;
                tick();
            end
        end
    endtask

    task automatic test_snoop_rr;
        int         seq[4] = '{2, 3, 0, 2};
        logic [3:0] exp;
        do_reset();
        // Leave the snoop pointer at core1 so rotation starts from core2.
        req_proc = 4'b0001;
        tick();
        req_snoop = 4'b0010;
        tick();
        tests_run++;
        if (gnt_snoop !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL snoop_setup: got %b, expected %b", gnt_snoop, 4'b0010);
        end
        req_snoop = '0;
        req_proc  = '0;
        tick();
        req_proc = 4'b0010;
        tick();
        req_snoop = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << seq[k];
            tests_run++;
            if ({gnt_proc, gnt_snoop, gnt_lv2} !== {4'b0010, exp, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL snoop_rr_grant %0d: got %b, expected %b",
                         k, {gnt_proc, gnt_snoop, gnt_lv2}, {4'b0010, exp, 1'b0});
            end
            if (k < 3) begin
                req_snoop = 4'b1111 & ~exp;
                tick();
                tests_run++;
                if ({gnt_proc, gnt_snoop} !== {4'b0010, 4'b0000}) begin
                    tests_failed++;
                    $display("[TB] FAIL snoop_rr_bubble %0d: got %b, expected %b",
                             k, {gnt_proc, gnt_snoop}, {4'b0010, 4'b0000});
                end
                req_snoop = 4'b1111;
                tick();
            end
        end
    endtask

    task automatic test_snoop_over_lv2;
        do_reset();
        req_proc = 4'b0001;
        tick();
        req_snoop = 4'b0010;
        req_lv2   = 1'b1;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop, gnt_lv2} !== {4'b0001, 4'b0010, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL snoop_before_lv2: got %b, expected %b",
                     {gnt_proc, gnt_snoop, gnt_lv2}, {4'b0001, 4'b0010, 1'b0});
        end
        req_snoop = '0;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop, gnt_lv2} !== {4'b0001, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL lv2_bubble: got %b, expected %b",
                     {gnt_proc, gnt_snoop, gnt_lv2}, {4'b0001, 4'b0000, 1'b0});
        end
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop, gnt_lv2} !== {4'b0001, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL lv2_grant: got %b, expected %b",
                     {gnt_proc, gnt_snoop, gnt_lv2}, {4'b0001, 4'b0000, 1'b1});
        end
        req_lv2 = 1'b0;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_lv2} !== {4'b0001, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL lv2_release: got %b, expected %b",
                     {gnt_proc, gnt_lv2}, {4'b0001, 1'b0});
        end
    endtask

    task automatic test_release_in_lv2;
        do_reset();
        req_proc = 4'b0100;
        tick();
        req_lv2 = 1'b1;
        tick();
        req_proc = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if ({gnt_proc, gnt_lv2, bus_busy, bus_owner_id} !== {4'b0000, 1'b1, 1'b1, 2'd2}) begin
                tests_failed++;
                $display("[TB] FAIL release_hold %0d: got %b, expected %b",
                         k, {gnt_proc, gnt_lv2, bus_busy, bus_owner_id}, {4'b0000, 1'b1, 1'b1, 2'd2});
            end
        end
        req_lv2 = 1'b0;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_lv2, bus_busy} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL release_idle: got %b, expected %b",
                     {gnt_proc, gnt_lv2, bus_busy}, 6'b0);
        end
        tick();
        tests_run++;
        if ({gnt_proc, bus_owner_id} !== {4'b0001, 2'd0}) begin
            tests_failed++;
            $display("[TB] FAIL release_next_owner: got %b, expected %b",
                     {gnt_proc, bus_owner_id}, {4'b0001, 2'd0});
        end
    endtask

    task automatic test_watchdog;
        logic exp_terr;
        do_reset();
        req_proc = 4'b1000;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_terr = (k > TMO);
            tests_run++;
            if ({gnt_proc, timeout_err} !== {4'b1000, exp_terr}) begin
                tests_failed++;
                $display("[TB] FAIL watchdog_cycle %0d: got %b, expected %b",
                         k, {gnt_proc, timeout_err}, {4'b1000, exp_terr});
            end
        end
        req_proc = '0;
        tick();
        tick();
        tests_run++;
        if ({gnt_proc, timeout_err} !== {4'b0000, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL watchdog_sticky: got %b, expected %b",
                     {gnt_proc, timeout_err}, {4'b0000, 1'b1});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL watchdog_clear: got %b, expected %b", timeout_err, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_proc = 4'b0001;
        tick();
        req_snoop = 4'b0100;
        tick();
        tests_run++;
        if (gnt_snoop !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL midreset_setup: got %b, expected %b", gnt_snoop, 4'b0100);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop, gnt_lv2, bus_busy, bus_owner_id} !== 12'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got %b, expected %b",
                     {gnt_proc, gnt_snoop, gnt_lv2, bus_busy, bus_owner_id}, 12'b0);
        end
        rst       = 1'b0;
        req_snoop = '0;
        req_proc  = 4'b1111;
        tick();
        tests_run++;
        if (gnt_proc !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL midreset_regrant: got %b, expected %b", gnt_proc, 4'b0001);
        end
    endtask

    task automatic test_random;
        logic [3:0]  flip, exp_gp, exp_gs;
        logic        exp_lv2;
        logic [12:0] exp_v, got_v;
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            flip = 4'($urandom) & 4'($urandom) & 4'($urandom);
            req_proc ^= flip;
            flip = 4'($urandom) & 4'($urandom);
            req_snoop ^= flip;
            if ($urandom_range(0, 3) == 0) req_lv2 = ~req_lv2;
            model_step();
            tick();
            exp_gp = '0;
            if (m_proc) exp_gp[m_owner] = 1'b1;
            exp_gs = '0;
            if (m_sub == 1) exp_gs[m_sidx] = 1'b1;
            exp_lv2 = (m_sub == 2);
            exp_v = {exp_gp, exp_gs, exp_lv2, (|exp_gp) | (|exp_gs) | exp_lv2, m_owner, m_terr};
            got_v = {gnt_proc, gnt_snoop, gnt_lv2, bus_busy, bus_owner_id, timeout_err};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle %0d: got %b, expected %b", c, got_v, exp_v);
            end
            tests_run++;
            if (!$onehot0(gnt_proc) || (gnt_snoop != 0 && gnt_lv2) ||
                (gnt_snoop & (4'b0001 << bus_owner_id)) != 0) begin
                tests_failed++;
                $display("[TB] FAIL random_invariants %0d: got %b, expected legal grant set",
                         c, {gnt_proc, gnt_snoop, gnt_lv2, bus_owner_id});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_proc  = '0;
        req_snoop = '0;
        req_lv2   = 1'b0;
        test_reset();
        test_proc_fairness();
        test_snoop_rr();
        test_snoop_over_lv2();
        test_release_in_lv2();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
